onchip_mem_arbiter: RTL and testbench

- Two-master Avalon-MM arbiter sharing the single-port 32-bit on-chip RAM: 15-bit word address, byteenable, 1-cycle read latency, unregistered output.
- Sits between the two system masters (e.g. Nios data master and the DMA/monitor engine) and the RAM slave.
- Provides round-robin grant, waitrequest back-pressure, registered readdatavalid, address-range protection and reset_req gating.

---
 rtl/onchip_mem_arbiter_if.sv | 23 ++
 rtl/onchip_mem_arbiter.sv | 83 ++++++++
 tb/tb_onchip_mem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM link between one system master and the on-chip RAM arbiter.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic              waitrequest;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Round-robin two-master arbiter for a single-port 1-cycle-latency RAM; grants are
// combinational, read data returns one cycle after acceptance, OOR accesses never reach the RAM.
module onchip_mem_arbiter #(
  parameter int          ADDR_W   = 15,
  parameter int unsigned DEPTH    = 30000,
  parameter logic [31:0] OOR_DATA = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 reset_req,
  onchip_mem_arbiter_if.slave  m0,
  onchip_mem_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [3:0]           mem_byteenable,
  output logic                 mem_chipselect,
  output logic                 mem_write,
  output logic [31:0]          mem_writedata,
  output logic                 mem_clken,
  input  logic [31:0]          mem_readdata,
  output logic [7:0]           oor_count
);

  logic        req0, req1;
  logic        winner, gnt, grant0, grant1;
  logic        win_read, win_write, oor;
  logic        last_grant, rdv_pending, rd_tag, rd_oor;
  logic [31:0] rd_data;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  always_comb begin
    winner = req1;
    if (req0 && req1) winner = ~last_grant;
  end

  // Grants are also withheld while reset_n is low so waiting masters see waitrequest.
  assign gnt    = reset_n & ~reset_req & (req0 | req1);
  assign grant0 = gnt & ~winner;
  assign grant1 = gnt & winner;

  assign m0.waitrequest = req0 & ~grant0;
  assign m1.waitrequest = req1 & ~grant1;

  assign win_write = winner ? m1.write : m0.write;
  assign win_read  = (winner ? m1.read : m0.read) & ~win_write;

  assign mem_address    = grant1 ? m1.address    : m0.address;
  assign mem_byteenable = grant1 ? m1.byteenable : m0.byteenable;
  assign mem_writedata  = grant1 ? m1.writedata  : m0.writedata;

  assign oor            = 32'(mem_address) >= DEPTH;
  assign mem_chipselect = gnt & ~oor;
  assign mem_write      = mem_chipselect & win_write;
  assign mem_clken      = ~reset_req;

  // RAM output is unregistered, so returned data is steered straight from mem_readdata.
  assign rd_data = rd_oor ? OOR_DATA : mem_readdata;

  assign m0.readdatavalid = rdv_pending & ~rd_tag;
  assign m1.readdatavalid = rdv_pending &  rd_tag;
  assign m0.readdata      = m0.readdatavalid ? rd_data : mem_readdata;
  assign m1.readdata      = m1.readdatavalid ? rd_data : mem_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant  <= 1'b1;
      rdv_pending <= 1'b0;
      rd_tag      <= 1'b0;
      rd_oor      <= 1'b0;
      oor_count   <= 8'd0;
    end else begin
      rdv_pending <= gnt & win_read;
      if (gnt) last_grant <= winner;
      if (gnt && win_read) begin
        rd_tag <= winner;
        rd_oor <= oor;
      end
      if (gnt && oor && oor_count != 8'hFF) oor_count <= oor_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Randomized and directed checks of onchip_mem_arbiter against a transaction-level model.
module tb_onchip_mem_arbiter;
  localparam int DEPTH = 30000;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [14:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } mreq_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reset_req = 1'b0;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
  logic [7:0]  oor_count;

  onchip_mem_arbiter_if m0_bus ();
  onchip_mem_arbiter_if m1_bus ();

  onchip_mem_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .reset_req      (reset_req),
    .m0             (m0_bus),
    .m1             (m1_bus),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .oor_count      (oor_count)
  );

  always #5 clk = ~clk;

  // RAM emulation: address registered on clken, output read combinationally.
  logic [31:0] ram [0:32767];
  logic [14:0] ram_addr_q = 15'd0;
  always @(posedge clk) begin
    if (mem_clken) begin
      if (mem_chipselect && mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  // Reference model state
  logic [31:0] ref_mem [0:32767];
  int          prio;
  bit          pend_v;
  int          pend_m;
  logic [31:0] pend_d;
  int          cnt;
  int          total, bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mreq_t idle();
    mreq_t r;
    r.rd = 1'b0; r.wr = 1'b0; r.addr = '0; r.be = '0; r.wd = '0;
    return r;
  endfunction

  function automatic mreq_t rdq(input logic [14:0] ad);
    mreq_t r;
    r = idle();
    r.rd = 1'b1; r.addr = ad; r.be = 4'hF;
    return r;
  endfunction

  function automatic mreq_t wrq(input logic [14:0] ad, input logic [3:0] be, input logic [31:0] d);
    mreq_t r;
    r = idle();
    r.wr = 1'b1; r.addr = ad; r.be = be; r.wd = d;
    return r;
  endfunction

  function automatic mreq_t randq();
    mreq_t r;
    int mode;
    r = idle();
    mode = $urandom_range(0, 9);
    r.rd = (mode >= 4 && mode <= 6) || mode == 9;
    r.wr = (mode >= 7);
    r.addr = ($urandom_range(0, 9) == 0) ? 15'($urandom_range(DEPTH, 32767))
                                          : 15'($urandom_range(0, 63));
    r.be = 4'($urandom);
    r.wd = $urandom;
    return r;
  endfunction

  // One bus cycle: drive, check outputs mid-cycle, then advance the model past the next edge.
  task automatic step(input logic rstn, input logic rq, input mreq_t a, input mreq_t b);
    mreq_t q[2];
    bit    req[2];
    bit    gnt, oor, w;
    int    win;
    q[0] = a; q[1] = b;
    @(posedge clk); #1;
    reset_n   = rstn;
    reset_req = rq;
    m0_bus.read = a.rd; m0_bus.write = a.wr; m0_bus.address = a.addr;
    m0_bus.byteenable = a.be; m0_bus.writedata = a.wd;
    m1_bus.read = b.rd; m1_bus.write = b.wr; m1_bus.address = b.addr;
    m1_bus.byteenable = b.be; m1_bus.writedata = b.wd;
    if (!rstn) begin
      pend_v = 0; prio = 0; cnt = 0;
    end
    req[0] = a.rd | a.wr;
    req[1] = b.rd | b.wr;
    gnt = rstn && !rq && (req[0] || req[1]);
    win = (req[0] && req[1]) ? prio : (req[1] ? 1 : 0);
    oor = gnt && (int'(q[win].addr) >= DEPTH);
    w   = q[win].wr;
    @(negedge clk);
    chk("m0_wait", m0_bus.waitrequest, req[0] && !(gnt && win == 0));
    chk("m1_wait", m1_bus.waitrequest, req[1] && !(gnt && win == 1));
    chk("clken", mem_clken, !rq);
    chk("chipselect", mem_chipselect, gnt && !oor);
    chk("mem_write", mem_write, gnt && !oor && w);
    if (gnt && !oor) chk("mem_addr", mem_address, q[win].addr);
    if (gnt && !oor && w) begin
      chk("mem_be", mem_byteenable, q[win].be);
      chk("mem_wdata", mem_writedata, q[win].wd);
    end
    chk("m0_rdv", m0_bus.readdatavalid, pend_v && pend_m == 0);
    chk("m1_rdv", m1_bus.readdatavalid, pend_v && pend_m == 1);
    if (pend_v) chk("rdata", (pend_m == 0) ? m0_bus.readdata : m1_bus.readdata, pend_d);
    chk("oor_count", oor_count, cnt);
    pend_v = 0;
    if (gnt) begin
      prio = 1 - win;
      if (oor && cnt < 255) cnt++;
      if (!w) begin
        pend_v = 1;
        pend_m = win;
        pend_d = oor ? 32'hDEADBEEF : ref_mem[q[win].addr];
      end else if (!oor) begin
        for (int k = 0; k < 4; k++)
          if (q[win].be[k]) ref_mem[q[win].addr][8*k +: 8] = q[win].wd[8*k +: 8];
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; prio = 0; pend_v = 0; pend_m = 0; pend_d = '0; cnt = 0;
    m0_bus.read = 0; m0_bus.write = 0; m0_bus.address = '0; m0_bus.byteenable = '0; m0_bus.writedata = '0;
    m1_bus.read = 0; m1_bus.write = 0; m1_bus.address = '0; m1_bus.byteenable = '0; m1_bus.writedata = '0;

    // Requests during reset must wait.
    step(0, 0, rdq(15'd1), rdq(15'd2));
    step(0, 0, idle(), idle());

    // Preload the low words used by the read traffic.
    for (int i = 0; i < 64; i++)
      step(1, 0, wrq(15'(i), 4'hF, 32'h1000_0000 + 32'(i) * 32'h0101_0101), idle());
    step(1, 0, wrq(15'd5, 4'hF, 32'h1122_3344), idle());

    // First cycle after reset: m0 read of addr 5.
    step(0, 0, idle(), idle());
    step(1, 0, rdq(15'd5), idle());
    step(1, 0, idle(), idle());

    // Contending writes alternate starting with m0, half-word byteenable.
    step(0, 0, idle(), idle());
    for (int k = 0; k < 4; k++)
      step(1, 0, wrq(15'(20 + k), 4'b0011, $urandom), wrq(15'(40 + k), 4'b0011, $urandom));
    for (int k = 0; k < 4; k++) step(1, 0, rdq(15'(20 + k)), idle());
    for (int k = 0; k < 4; k++) step(1, 0, idle(), rdq(15'(40 + k)));

    // Back-to-back reads from different masters.
    step(1, 0, idle(), rdq(15'd10));
    step(1, 0, rdq(15'd11), idle());
    step(1, 0, idle(), idle());

    // Out-of-range write and read, then saturation.
    step(0, 0, idle(), idle());
    step(1, 0, wrq(15'd30000, 4'hF, 32'h5555_AAAA), idle());
    step(1, 0, rdq(15'd32767), idle());
    step(1, 0, idle(), idle());
    chk("oor_two", oor_count, 32'd2);
    for (int i = 0; i < 300; i++)
      step(1, 0, (i % 2 == 0) ? wrq(15'(DEPTH + i), 4'hF, $urandom) : rdq(15'(DEPTH + i)), idle());
    step(1, 0, idle(), idle());
    chk("oor_sat", oor_count, 32'd255);

    // reset_req blocks grants; the read accepted just before is still delivered.
    step(1, 0, rdq(15'd7), idle());
    for (int i = 0; i < 3; i++) step(1, 1, rdq(15'd7), idle());
    step(1, 0, rdq(15'd7), idle());
    step(1, 0, idle(), idle());

    // Reset mid-read cancels the strobe; next contention goes to m0.
    step(1, 0, idle(), rdq(15'd8));
    step(0, 0, idle(), idle());
    step(1, 0, rdq(15'd9), rdq(15'd12));
    step(1, 0, idle(), idle());

    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0), randq(), randq());
    step(1, 0, idle(), idle());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
